// File: rtl/child_dispatch_pkg.sv
// Shared types and the round-robin lane picker
// for the child fan-out dispatcher.
package child_dispatch_pkg;

  localparam int NUM_LANES_DEFAULT = 5;
  localparam int MAX_LANES = 16;

  typedef logic [$clog2(NUM_LANES_DEFAULT)-1:0] lane_idx_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // Scans downward so the last hit kept is the lowest offset from ptr.
  function automatic pick_t rr_pick(
    input logic [MAX_LANES-1:0] free_vec,
    input logic [3:0]           ptr,
    input logic [4:0]           n
  );
    pick_t      r;
    logic [4:0] j;
    r = '0;
    for (int k = MAX_LANES - 1; k >= 0; k--) begin
      if (5'(k) < n) begin
        j = 5'(ptr) + 5'(k);
        if (j >= n) j = j - n;
        if (free_vec[j[3:0]]) begin
          r.found = 1'b1;
          r.idx   = j[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/child_fanout_dispatcher_lane.sv
// One-entry output register slice with a saturating
// dispatch counter; one instance per child lane.
module dispatch_lane_reg
  import child_dispatch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;
  assign o_free  = !r_valid || i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/child_fanout_dispatcher.sv
// Round-robin, work-conserving fan-out of one
// valid/ready stream onto NUM_LANES child lanes.
module child_fanout_dispatcher
  import child_dispatch_pkg::*;
#(
  parameter int NUM_LANES = 5,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic [NUM_LANES-1:0]        out_valid,
  input  logic [NUM_LANES-1:0]        out_ready,
  output logic [NUM_LANES*DATA_W-1:0] out_data,
  output logic [NUM_LANES*CNT_W-1:0]  lane_cnt,
  output logic [$clog2(NUM_LANES)-1:0] rr_ptr
);

  localparam int IDX_W = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0] w_free;
  logic [NUM_LANES-1:0] w_load;
  logic [MAX_LANES-1:0] w_free_ext;
  pick_t                w_pick;
  logic [IDX_W-1:0]     w_target;
  logic                 w_accept;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic                 w_unused_idx;

  assign w_free_ext   = MAX_LANES'(w_free);
  assign w_pick       = rr_pick(w_free_ext, 4'(r_rr_ptr), 5'(NUM_LANES));
  assign w_target     = w_pick.idx[IDX_W-1:0];
  assign w_unused_idx = ^w_pick.idx;

  // Combinational through out_ready so a draining lane refills same cycle.
  assign in_ready = w_pick.found && !flush && !rst;
  assign w_accept = in_valid && in_ready;
  assign rr_ptr   = r_rr_ptr;

  always_comb begin
    w_load = '0;
    if (w_accept) w_load[w_target] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (flush) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      if (w_target == IDX_W'(NUM_LANES - 1)) r_rr_ptr <= '0;
      else r_rr_ptr <= w_target + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dispatch_lane_reg #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_load  (w_load[g]),
      .i_data  (in_data),
      .i_ready (out_ready[g]),
      .o_valid (out_valid[g]),
      .o_data  (out_data[g*DATA_W +: DATA_W]),
      .o_cnt   (lane_cnt[g*CNT_W +: CNT_W]),
      .o_free  (w_free[g])
    );
  end

endmodule

// File: tb/tb_child_fanout_dispatcher.sv
// Directed bench for child_fanout_dispatcher
// (5 lanes, 32-bit data, 4-bit counters).
module tb_child_fanout_dispatcher;

  localparam int NL = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [NL-1:0]   out_valid;
  logic [NL-1:0]   out_ready;
  logic [NL*DW-1:0] out_data;
  logic [NL*CW-1:0] lane_cnt;
  logic [2:0]      rr_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  child_fanout_dispatcher #(
    .NUM_LANES (NL),
    .DATA_W    (DW),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .lane_cnt  (lane_cnt),
    .rr_ptr    (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ld(input int i);
    return out_data[i*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] lc(input int i);
    return lane_cnt[i*CW +: CW];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    @(negedge clk);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = '1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== '0 || rr_ptr !== '0 || lane_cnt !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ov=%b ptr=%0d cnt=%h want 0/0/0", out_valid, rr_ptr, lane_cnt);
    end
    in_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = '1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h100 + k;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", k, in_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (rr_ptr !== 3'((k + 1) % NL) || ld(k % NL) !== 32'h100 + k || !out_valid[k % NL]) begin
        n_fail++;
        $display("FAIL stream_word[%0d]: ptr=%0d data=%h want ptr=%0d data=%h", k, rr_ptr, ld(k % NL), (k + 1) % NL, 32'h100 + k);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < NL; i++) begin
      n_checks++;
      if (lc(i) !== 4'd2 || ld(i) !== 32'h105 + i) begin
        n_fail++;
        $display("FAIL stream_lane[%0d]: cnt=%0d data=%h want 2 %h", i, lc(i), ld(i), 32'h105 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = '0;
    for (int k = 0; k < 5; k++) push(32'h100 + k);
    n_checks++;
    if (out_valid !== 5'b11111 || rr_ptr !== 3'd0) begin
      n_fail++; $display("FAIL bp_full: ov=%b ptr=%0d want 11111 0", out_valid, rr_ptr);
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h105;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_stall_ready: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ld(2) !== 32'h102 || rr_ptr !== 3'd0 || lc(2) !== 4'd1) begin
      n_fail++; $display("FAIL bp_hold: data=%h ptr=%0d want 102 0", ld(2), rr_ptr);
    end
    @(negedge clk);
    out_ready = 5'b00100;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (ld(2) !== 32'h105 || out_valid !== 5'b11111 || rr_ptr !== 3'd3 || lc(2) !== 4'd2) begin
      n_fail++;
      $display("FAIL bp_refill: data=%h ov=%b ptr=%0d cnt=%0d want 105 11111 3 2", ld(2), out_valid, rr_ptr, lc(2));
    end
  endtask

  task automatic test_wrap_skip();
    @(negedge clk);
    out_ready = 5'b00001;
    in_valid = 1'b1; in_data = 32'h200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (ld(0) !== 32'h200 || rr_ptr !== 3'd1 || ld(3) !== 32'h103 || ld(4) !== 32'h104) begin
      n_fail++; $display("FAIL wrap_skip: l0=%h ptr=%0d want 200 1", ld(0), rr_ptr);
    end
    out_ready = '0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) push(32'h300 + k);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h3AA;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== '0 || rr_ptr !== 3'd0 || ld(0) !== 32'h300) begin
      n_fail++; $display("FAIL flush_state: ov=%b ptr=%0d l0=%h want 0 0 300", out_valid, rr_ptr, ld(0));
    end
    n_checks++;
    if (lane_cnt !== 20'h00111) begin
      n_fail++; $display("FAIL flush_cnt: got %h want 00111", lane_cnt);
    end
    push(32'h3BB);
    n_checks++;
    if (out_valid !== 5'b00001 || ld(0) !== 32'h3BB || rr_ptr !== 3'd1) begin
      n_fail++; $display("FAIL flush_next: ov=%b l0=%h want 00001 3bb", out_valid, ld(0));
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 5; k++) push(32'h400 + k);
    out_ready = 5'b00001;
    for (int k = 0; k < 19; k++) push(32'h500 + k);
    n_checks++;
    if (lc(0) !== 4'd15 || lc(1) !== 4'd1 || ld(0) !== 32'h512) begin
      n_fail++; $display("FAIL saturate: cnt0=%0d cnt1=%0d l0=%h want 15 1 512", lc(0), lc(1), ld(0));
    end
    out_ready = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    push(32'h600);
    push(32'h601);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h6FF;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== '0 || lane_cnt !== '0 || rr_ptr !== '0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: ov=%b cnt=%h ptr=%0d rdy=%b want all 0", out_valid, lane_cnt, rr_ptr, in_ready);
    end
    @(negedge clk);
    rst = 1'b0; in_data = 32'h610;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 5'b00001 || ld(0) !== 32'h610 || rr_ptr !== 3'd1) begin
      n_fail++; $display("FAIL post_rst: ov=%b l0=%h ptr=%0d want 00001 610 1", out_valid, ld(0), rr_ptr);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap_skip();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
